aw_split_ctrl: RTL

AW_SPLIT_CTRL -- requirements
Module: aw_split_ctrl

---
 rtl/aw_split_ctrl_if.sv | 29 ++
 rtl/aw_split_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/aw_split_ctrl_if.sv
// AW/B handshake bundle between the master selector, the burst-split controller and the slave port.
// The slave modport is the controller's view; the master modport is the surrounding fabric's view.
interface aw_split_ctrl_if #(
    parameter int AXI4_Aw_len = 8
);
    logic                   M_awvalid;
    logic [AXI4_Aw_len-1:0] M_awlen;
    logic                   M_awready;
    logic                   Load_The_Original_Signals;
    logic                   Token;
    logic                   Burst_Out;
    logic                   S_awready;
    logic                   S_bvalid;
    logic [1:0]             S_bresp;
    logic                   S_bready;
    logic                   M_bvalid;
    logic [1:0]             M_bresp;
    logic                   M_bready;

    modport slave (
        input  M_awvalid, M_awlen, S_awready, S_bvalid, S_bresp, M_bready,
        output M_awready, Load_The_Original_Signals, Token, Burst_Out, S_bready, M_bvalid, M_bresp
    );

    modport master (
        output M_awvalid, M_awlen, S_awready, S_bvalid, S_bresp, M_bready,
        input  M_awready, Load_The_Original_Signals, Token, Burst_Out, S_bready, M_bvalid, M_bresp
    );
endinterface

// File: rtl/aw_split_ctrl.sv
// Splits one AXI4 AW burst into 16-beat sub-bursts and merges their B responses (worst resp wins).
// Optional B-response watchdog enabled by defining AW_SPLIT_WDOG_EN.
module aw_split_ctrl #(
    parameter int AXI4_Aw_len = 8,
    parameter int WDOG_CYCLES = 256
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    aw_split_ctrl_if.slave    bus,
    output logic [2:0]        state_dbg
);
    // Handshakes: a transfer happens on any rising edge where valid and ready are both 1;
    // Token is the sub-burst valid and holds until S_awready, M_bvalid holds until M_bready.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ISSUE  = 3'd2,
        WAIT_B = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [4:0] issue_cnt;
    logic [4:0] out_cnt, out_cnt_nxt;
    logic [1:0] resp_acc;
    logic       burst_fire, b_ready, b_hs, b_take, wdog_fire;

    assign burst_fire = (state == ISSUE) & bus.S_awready;
    assign b_ready    = (state == ISSUE) | (state == WAIT_B);
    assign b_hs       = bus.S_bvalid & b_ready;
    // A response with nothing outstanding is dropped so out_cnt can never wrap
    assign b_take     = b_hs & (out_cnt != 5'd0);
    assign state_dbg  = state;

    always_comb begin
        out_cnt_nxt = out_cnt;
        if (burst_fire && !b_take)
            out_cnt_nxt = out_cnt + 5'd1;
        else if (!burst_fire && b_take)
            out_cnt_nxt = out_cnt - 5'd1;
    end

`ifdef AW_SPLIT_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt;

    always_ff @(posedge ACLK) begin
        if (!ARESETN || state != WAIT_B || b_hs)
            wdog_cnt <= '0;
        else
            wdog_cnt <= wdog_cnt + 1'b1;
    end

    assign wdog_fire = (state == WAIT_B) && !b_hs && (wdog_cnt == WW'(WDOG_CYCLES - 1));
`else
    // Limit is meaningless without the watchdog; WAIT_B simply waits
    assign wdog_fire = (WDOG_CYCLES < 0);
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state     <= IDLE;
            issue_cnt <= 5'd0;
            out_cnt   <= 5'd0;
            resp_acc  <= 2'b00;
        end else begin
            state <= state_nxt;
            if (state == LOAD) begin
                issue_cnt <= 5'(bus.M_awlen >> 4) + 5'd1;
                out_cnt   <= 5'd0;
                resp_acc  <= 2'b00;
            end else begin
                if (burst_fire)
                    issue_cnt <= issue_cnt - 5'd1;
                out_cnt <= out_cnt_nxt;
                if (b_take && (bus.S_bresp > resp_acc))
                    resp_acc <= bus.S_bresp;
                if (wdog_fire) begin
                    out_cnt  <= 5'd0;
                    resp_acc <= 2'b10;
                end
            end
        end
    end

    always_comb begin
        state_nxt                     = state;
        bus.M_awready                 = 1'b0;
        bus.Load_The_Original_Signals = 1'b0;
        bus.Token                     = 1'b0;
        bus.Burst_Out                 = 1'b0;
        bus.S_bready                  = 1'b0;
        bus.M_bvalid                  = 1'b0;
        bus.M_bresp                   = 2'b00;
        unique case (state)
            IDLE: begin
                if (bus.M_awvalid)
                    state_nxt = LOAD;
            end
            LOAD: begin
                bus.M_awready                 = 1'b1;
                bus.Load_The_Original_Signals = 1'b1;
                state_nxt                     = ISSUE;
            end
            ISSUE: begin
                bus.Token     = 1'b1;
                bus.Burst_Out = burst_fire;
                bus.S_bready  = 1'b1;
                if (burst_fire && issue_cnt == 5'd1)
                    state_nxt = WAIT_B;
            end
            WAIT_B: begin
                bus.S_bready = 1'b1;
                if ((issue_cnt == 5'd0 && out_cnt_nxt == 5'd0) || wdog_fire)
                    state_nxt = RESP;
            end
            RESP: begin
                bus.M_bvalid = 1'b1;
                bus.M_bresp  = resp_acc;
                if (bus.M_bready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
